vending_machine_param: RTL and testbench

- Parametrised successor to the fixed-price two-coin vending FSM.
- Accumulates credit from two coin inputs of configurable value against a configurable product price.
- Dispenses one product when credit reaches the price, then returns excess credit as a train of one-unit change pulses.
- Adds cancel/refund, coin rejection and a visible credit register; sits between the coin-acceptor front end and the dispenser/change-hopper drivers.

---
 rtl/vending_machine_param.sv | 154 +++++++++++++++
 tb/tb_vending_machine_param.sv | 125 ++++++++++++
 2 files changed

// File: rtl/vending_machine_param.sv
// Parametrised vending FSM: coin credit, single-product dispense, unit change train, cancel/refund.
// Optional idle-credit timeout in COLLECT is enabled by defining VM_TIMEOUT_EN.
module vending_machine_param #(
  parameter int CREDIT_W    = 4,
  parameter int PRICE       = 3,
  parameter int COIN_A_VAL  = 1,
  parameter int COIN_B_VAL  = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_a,
  input  logic                coin_b,
  input  logic                cancel,
  output logic                prod,
  output logic                change,
  output logic                coin_rej,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  localparam int MAX_COIN  = (COIN_A_VAL > COIN_B_VAL) ? COIN_A_VAL : COIN_B_VAL;
  localparam int MAX_CRED  = (2 ** CREDIT_W) - 1;
  localparam logic [CREDIT_W-1:0] PRICE_V = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] A_VAL_V = CREDIT_W'(COIN_A_VAL);
  localparam logic [CREDIT_W-1:0] B_VAL_V = CREDIT_W'(COIN_B_VAL);
  localparam logic [CREDIT_W-1:0] ONE_V   = CREDIT_W'(1);

  if (PRICE < 1 || PRICE > MAX_CRED || COIN_A_VAL < 1 || COIN_B_VAL < 1 ||
      (PRICE - 1 + MAX_COIN) > MAX_CRED) begin : g_param_check
    $fatal(1, "vending_machine_param: illegal PRICE/COIN/CREDIT_W combination");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VEND    = 2'd2,
    S_REFUND  = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [CREDIT_W-1:0] credit_r, credit_s, coin_val_s, sum_s;
  logic                prod_r, change_r, coin_rej_r, busy_r;
  logic                prod_s, change_s, coin_rej_s, busy_s;
  logic                coin_valid_s, coin_any_s, quit_s, timeout_s;

`ifdef VM_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_r;

  if (TIMEOUT_CYC < 1) begin : g_timeout_check
    $fatal(1, "vending_machine_param: TIMEOUT_CYC must be at least 1");
  end

  // Idle-credit counter: runs only while credit sits in COLLECT with no valid coin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_r <= '0;
    end else if (state_r == S_COLLECT && state_s == S_COLLECT && !coin_valid_s) begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end else begin
      to_cnt_r <= '0;
    end
  end

  assign timeout_s = (state_r == S_COLLECT) && (to_cnt_r == TO_W'(TIMEOUT_CYC));
`else
  assign timeout_s = 1'b0;
`endif

  assign coin_valid_s = coin_a ^ coin_b;
  assign coin_any_s   = coin_a | coin_b;
  assign coin_val_s   = coin_a ? A_VAL_V : B_VAL_V;
  assign sum_s        = credit_r + coin_val_s;
  assign quit_s       = cancel | timeout_s;

  // Next-state, next-credit and next-output decode.
  always_comb begin
    state_s    = state_r;
    credit_s   = credit_r;
    prod_s     = 1'b0;
    change_s   = 1'b0;
    coin_rej_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (coin_valid_s) begin
          credit_s = coin_val_s;
          state_s  = (coin_val_s >= PRICE_V) ? S_VEND : S_COLLECT;
        end else begin
          coin_rej_s = coin_a & coin_b;
        end
      end
      S_COLLECT: begin
        if (quit_s) begin
          // Refund covers only the credit already held; a simultaneous coin goes back.
          state_s    = S_REFUND;
          coin_rej_s = coin_any_s;
        end else if (coin_valid_s) begin
          credit_s = sum_s;
          state_s  = (sum_s >= PRICE_V) ? S_VEND : S_COLLECT;
        end else begin
          coin_rej_s = coin_a & coin_b;
        end
      end
      S_VEND: begin
        prod_s     = 1'b1;
        credit_s   = credit_r - PRICE_V;
        state_s    = (credit_r == PRICE_V) ? S_IDLE : S_REFUND;
        coin_rej_s = coin_any_s;
      end
      S_REFUND: begin
        coin_rej_s = coin_any_s;
        if (credit_r == '0) begin
          state_s = S_IDLE;
        end else begin
          change_s = 1'b1;
          credit_s = credit_r - ONE_V;
          state_s  = (credit_r == ONE_V) ? S_IDLE : S_REFUND;
        end
      end
      default: begin
        state_s  = S_IDLE;
        credit_s = '0;
      end
    endcase
    busy_s = (state_s == S_VEND) || (state_s == S_REFUND);
  end

  // State, credit and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      credit_r   <= '0;
      prod_r     <= 1'b0;
      change_r   <= 1'b0;
      coin_rej_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      credit_r   <= credit_s;
      prod_r     <= prod_s;
      change_r   <= change_s;
      coin_rej_r <= coin_rej_s;
      busy_r     <= busy_s;
    end
  end

  assign prod     = prod_r;
  assign change   = change_r;
  assign coin_rej = coin_rej_r;
  assign busy     = busy_r;
  assign credit   = credit_r;

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed bench for vending_machine_param at default parameters (PRICE=3, A=1, B=2).
// Flags are compared as {prod, change, coin_rej, busy}.
module tb_vending_machine_param;

  logic       clk;
  logic       rst_n;
  logic       coin_a, coin_b, cancel;
  logic       prod, change, coin_rej, busy;
  logic [3:0] credit;

  int n_checks;
  int n_err;

  vending_machine_param #(
    .CREDIT_W(4), .PRICE(3), .COIN_A_VAL(1), .COIN_B_VAL(2), .TIMEOUT_CYC(255)
  ) dut (
    .clk(clk), .rst_n(rst_n), .coin_a(coin_a), .coin_b(coin_b), .cancel(cancel),
    .prod(prod), .change(change), .coin_rej(coin_rej), .busy(busy), .credit(credit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] flags, input logic [3:0] cred);
    chk({tag, ".flags"}, {4'd0, prod, change, coin_rej, busy}, {4'd0, flags});
    chk({tag, ".credit"}, {4'd0, credit}, {4'd0, cred});
  endtask

  // One clock: drive at negedge, let the posedge act, then release pulses.
  task automatic cyc(input logic a, input logic b, input logic c);
    @(negedge clk);
    coin_a = a; coin_b = b; cancel = c;
    @(posedge clk);
    #1;
    coin_a = 1'b0; coin_b = 1'b0; cancel = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_err = 0;
    rst_n = 1'b0; coin_a = 1'b0; coin_b = 1'b0; cancel = 1'b0;
    #12;
    expect_out("reset", 4'b0000, 4'd0);
    @(negedge clk); rst_n = 1'b1;

    // Three coin_a: exact price, no change
    cyc(1'b1, 1'b0, 1'b0); expect_out("a1", 4'b0000, 4'd1);
    cyc(1'b1, 1'b0, 1'b0); expect_out("a2", 4'b0000, 4'd2);
    cyc(1'b1, 1'b0, 1'b0); expect_out("a3_vend", 4'b0001, 4'd3);
    cyc(1'b0, 1'b0, 1'b0); expect_out("a3_prod", 4'b1000, 4'd0);
    cyc(1'b0, 1'b0, 1'b0); expect_out("a3_idle", 4'b0000, 4'd0);

    // Two coin_b: overpay by one
    cyc(1'b0, 1'b1, 1'b0); expect_out("b1", 4'b0000, 4'd2);
    cyc(1'b0, 1'b1, 1'b0); expect_out("b2_vend", 4'b0001, 4'd4);
    cyc(1'b0, 1'b0, 1'b0); expect_out("b2_prod", 4'b1001, 4'd1);
    cyc(1'b0, 1'b0, 1'b0); expect_out("b2_chg", 4'b0100, 4'd0);
    cyc(1'b0, 1'b0, 1'b0); expect_out("b2_idle", 4'b0000, 4'd0);

    // coin_b then cancel: two change pulses, no product
    cyc(1'b0, 1'b1, 1'b0); expect_out("cn_b", 4'b0000, 4'd2);
    cyc(1'b0, 1'b0, 1'b1); expect_out("cn_ref", 4'b0001, 4'd2);
    cyc(1'b0, 1'b0, 1'b0); expect_out("cn_chg1", 4'b0101, 4'd1);
    cyc(1'b0, 1'b0, 1'b0); expect_out("cn_chg2", 4'b0100, 4'd0);
    cyc(1'b0, 1'b0, 1'b0); expect_out("cn_idle", 4'b0000, 4'd0);

    // Both coins at once from IDLE
    cyc(1'b1, 1'b1, 1'b0); expect_out("dual_rej", 4'b0010, 4'd0);
    cyc(1'b0, 1'b0, 1'b0); expect_out("dual_idle", 4'b0000, 4'd0);

    // coin_a during REFUND is rejected, refund count unaffected
    cyc(1'b0, 1'b1, 1'b0); expect_out("rr_b", 4'b0000, 4'd2);
    cyc(1'b0, 1'b0, 1'b1); expect_out("rr_ref", 4'b0001, 4'd2);
    cyc(1'b1, 1'b0, 1'b0); expect_out("rr_rej", 4'b0111, 4'd1);
    cyc(1'b0, 1'b0, 1'b0); expect_out("rr_chg2", 4'b0100, 4'd0);
    cyc(1'b0, 1'b0, 1'b0); expect_out("rr_idle", 4'b0000, 4'd0);

    // cancel with a coin in COLLECT: cancel wins, coin rejected
    cyc(1'b1, 1'b0, 1'b0); expect_out("cc_a", 4'b0000, 4'd1);
    cyc(1'b0, 1'b1, 1'b1); expect_out("cc_rej", 4'b0011, 4'd1);
    cyc(1'b0, 1'b0, 1'b0); expect_out("cc_chg", 4'b0100, 4'd0);
    cyc(1'b0, 1'b0, 1'b0); expect_out("cc_idle", 4'b0000, 4'd0);

    // cancel in IDLE ignored
    cyc(1'b0, 1'b0, 1'b1); expect_out("idle_cancel", 4'b0000, 4'd0);

    // Coin during VEND rejected; product still dispensed
    cyc(1'b0, 1'b1, 1'b0); expect_out("vr_b", 4'b0000, 4'd2);
    cyc(1'b1, 1'b0, 1'b0); expect_out("vr_vend", 4'b0001, 4'd3);
    cyc(1'b0, 1'b1, 1'b0); expect_out("vr_prod_rej", 4'b1010, 4'd0);
    cyc(1'b0, 1'b0, 1'b0); expect_out("vr_idle", 4'b0000, 4'd0);

    // Cancel in VEND ignored
    cyc(1'b0, 1'b1, 1'b0); expect_out("vc_b", 4'b0000, 4'd2);
    cyc(1'b0, 1'b1, 1'b0); expect_out("vc_vend", 4'b0001, 4'd4);
    cyc(1'b0, 1'b0, 1'b1); expect_out("vc_prod", 4'b1001, 4'd1);
    cyc(1'b0, 1'b0, 1'b0); expect_out("vc_chg", 4'b0100, 4'd0);

    // Asynchronous reset mid-REFUND with credit=1
    cyc(1'b0, 1'b1, 1'b0); expect_out("ar_b", 4'b0000, 4'd2);
    cyc(1'b0, 1'b0, 1'b1); expect_out("ar_ref", 4'b0001, 4'd2);
    cyc(1'b0, 1'b0, 1'b0); expect_out("ar_chg1", 4'b0101, 4'd1);
    #2 rst_n = 1'b0;
    #1 expect_out("ar_async", 4'b0000, 4'd0);
    @(negedge clk); rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0); expect_out("ar_post1", 4'b0000, 4'd0);
    cyc(1'b0, 1'b0, 1'b0); expect_out("ar_post2", 4'b0000, 4'd0);

    // Machine usable after reset
    cyc(1'b1, 1'b0, 1'b0); expect_out("pr_a", 4'b0000, 4'd1);
    cyc(1'b0, 1'b1, 1'b0); expect_out("pr_vend", 4'b0001, 4'd3);
    cyc(1'b0, 1'b0, 1'b0); expect_out("pr_prod", 4'b1000, 4'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
